// File: rtl/vl_rec_echo_fifo.sv
// vl_rec_echo_fifo: FWFT echo FIFO for vl_rec records {vl_bit, vl_arr[3:0]}; `VL_REC_PARITY_EN adds even-parity filtering
module vl_rec_echo_fifo #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       in_data,
`ifdef VL_REC_PARITY_EN
  input  logic             in_par,
  output logic             out_par,
  output logic [CNT_W-1:0] err_count,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [4:0]       out_data,
  output logic [CNT_W-1:0] rx_count,
  output logic [CNT_W-1:0] tx_count,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  logic [CNT_W-1:0] rx_q, rx_d, tx_q, tx_d;
  logic [4:0] mem [DEPTH];
  logic push, pop, store;
`ifdef VL_REC_PARITY_EN
  logic [CNT_W-1:0] err_q, err_d;
  logic bad;
`endif
  // pointer compare, handshakes, and next-state of pointers and counters
  always_comb begin
    full = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    empty = wp_q == rp_q;
    in_ready = !full;
    out_valid = !empty;
    out_data = mem[rp_q[AW-1:0]];
    push = in_valid && in_ready;
    pop = out_valid && out_ready;
`ifdef VL_REC_PARITY_EN
    bad = ^{in_data, in_par};
    store = push && !bad;
    err_d = (push && bad && !(&err_q)) ? err_q + CNT_W'(1) : err_q;
    out_par = ^out_data;
    err_count = err_q;
`else
    store = push;
`endif
    wp_d = wp_q + (AW+1)'(store);
    rp_d = rp_q + (AW+1)'(pop);
    rx_d = rx_q + CNT_W'(push);
    tx_d = tx_q + CNT_W'(pop);
    rx_count = rx_q;
    tx_count = tx_q;
  end
  // record storage; contents need no reset since the pointers gate visibility
  always_ff @(posedge clk) begin
    if (store) mem[wp_q[AW-1:0]] <= in_data;
  end
  // pointer and counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp_q <= '0;
      rp_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
`ifdef VL_REC_PARITY_EN
      err_q <= '0;
`endif
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
      rx_q <= rx_d;
      tx_q <= tx_d;
`ifdef VL_REC_PARITY_EN
      err_q <= err_d;
`endif
    end
  end
endmodule

// File: doc/vl_rec_echo_fifo.md
# vl_rec_echo_fifo

Responder end of the `vl_rec` record link: accepts `vl_rec` records (from `common_vl_pack`) from a sender over a valid/ready handshake. Buffers them in a DEPTH-entry first-word-fall-through FIFO and returns them unchanged, in order, over a second valid/ready handshake. It sits opposite the record sender in the mixed-language package-sharing designs. It also keeps free-running accept/return counters for bench checking.

## Interface
Parameters:
- `DEPTH`, 4, FIFO entries; power of two, ≥2
- `CNT_W`, 8, width of `rx_count`/`tx_count`

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `in_valid`  in  1  sender presents a record
- `in_ready`  out  1  block can accept a record
- `in_data`  in  vl_rec (5: `vl_bit`, `vl_arr[3:0]`)  inbound record
- `out_valid`  out  1  record available at head
- `out_ready`  in  1  consumer takes head record
- `out_data`  out  vl_rec (5)  head record
- `rx_count`  out  CNT_W  records accepted since reset
- `tx_count`  out  CNT_W  records returned since reset
- `full`, `empty`  out  1 each  occupancy == DEPTH / == 0

## Operation
- Push: `in_valid && in_ready` at a rising edge writes `in_data` at the write pointer and advances it.
- Pop: `out_valid && out_ready` at a rising edge advances the read pointer.
- Pointers are log2(DEPTH)+1 bits. Full = MSBs differ and low bits equal. Empty = pointers equal. Wrap-around is natural modulo 2·DEPTH.
- `in_ready = !full`; `out_valid = !empty`. `in_ready` never depends on `out_ready`, so there is no combinational path in→out.
- `out_data` = memory[read pointer], combinational from storage. Value when `empty` is don't-care; the bench must not check it.
- Records are returned bit-exact: `vl_bit` and all four `vl_arr` bits unchanged, strict FIFO order.
- Simultaneous push and pop when neither full nor empty: both occur, occupancy unchanged.
- Push and pop while full: only the pop occurs, because `in_ready`=0.
- Pop while empty: impossible, because `out_valid`=0.
- `in_valid` may drop without a handshake; nothing is stored. The sender must hold `in_data` stable while `in_valid && !in_ready`.
- Counters: `rx_count` +1 per push, `tx_count` +1 per pop. Both wrap modulo 2^CNT_W.

## Timing
- Reset (`rst_n`=0, asynchronous, any time including mid-transfer):
  - pointers and counters go to 0
  - `empty`=1, `full`=0, `in_ready`=1, `out_valid`=0
  - all buffered records are discarded
- After `rst_n` rises, the first push is allowed at the first rising edge.
- Latency: a record pushed at edge N drives `out_valid`=1 and `out_data` right after edge N, and is poppable at edge N+1 (one-cycle fall-through).
- Sustained throughput is one record per cycle with `out_ready` held at 1.
- `full` rises right after the edge of the DEPTH-th unpopped push. It falls right after the next pop edge.

## Configuration
- `VL_REC_PARITY_EN` defined:
  - Adds input `in_par` (1) and outputs `out_par` (1) and `err_count` (CNT_W).
  - A handshaked record with `^{in_data, in_par}` ≠ 0 (even parity failure) is consumed: the handshake completes but the record is not stored, the pointers do not move, and `rx_count` still increments.
  - `err_count` increments, saturating at 2^CNT_W−1, and resets to 0.
  - `out_par = ^out_data`.
- `VL_REC_PARITY_EN` undefined: those ports do not exist and every handshaked record is stored.

## Test plan
- Reset then idle: `in_ready`=1, `out_valid`=0, `empty`=1, counts 0.
- Push 5'b1_0110 and hold `out_ready`=0: after the edge, `out_valid`=1, `out_data`=5'b1_0110, `rx_count`=1. Raise `out_ready`: popped at the next edge, `tx_count`=1, `empty`=1.
- Push 4 records with `out_ready`=0: `full`=1 and `in_ready`=0. A 5th `in_valid` is not accepted (`rx_count` stays 4). Then drain: outputs appear in push order.
- Stream 300 random records with `out_ready`=1 every cycle: all records match in order, `rx_count`=`tx_count`=44 (300 mod 256), occupancy never exceeds 1.
- Assert `rst_n`=0 with 3 entries buffered, mid-cycle: all outputs return to their reset values immediately, and no stale record appears after release.
- `VL_REC_PARITY_EN` defined: push 5'b0_0001 with `in_par`=0 → not stored, `err_count`=1, `rx_count`=1. Push 5'b0_0001 with `in_par`=1 → stored, `out_par`=1.
